reg8_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one 8-bit synchronously-reset holding register between NREQ requesters.
- Each requester offers a byte with a valid/ready handshake; exactly one write is granted per arbitration.
- After each write the register is held stable for HOLD_CYCLES cycles before the next grant.
- Sits between producer blocks and any consumer that reads the registered byte.

---
 rtl/reg8_wr_arbiter_pkg.sv | 15 +
 rtl/reg8_wr_arbiter_if.sv | 26 ++
 rtl/reg8_en.sv | 25 ++
 rtl/reg8_wr_arbiter.sv | 111 +++++++++++
 tb/tb_reg8_wr_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/reg8_wr_arbiter_pkg.sv
// Shared types and default constants for the reg8_wr_arbiter slice.
// Build option REG8_WR_ARB_PRIO0_EN (see reg8_wr_arbiter.sv) changes no types here.
package reg8_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int HOLD_DEF  = 2;
  localparam int PTR_W_DEF = $clog2(NREQ_DEF);

endpackage

// File: rtl/reg8_wr_arbiter_if.sv
// Requester/consumer bus of the shared-register write arbiter.
// master = producer/consumer side, slave = arbiter side.
interface reg8_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        q;
  logic                    q_valid;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, q, q_valid, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, q, q_valid, grant_id, busy
  );

endinterface

// File: rtl/reg8_en.sv
// WIDTH-bit data register with load enable and synchronous active-high reset to 0.
module reg8_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg8_wr_arbiter.sv
// Round-robin write arbiter sharing one held register between NREQ requesters.
// Define REG8_WR_ARB_PRIO0_EN to give requester 0 strict priority over the rotation.
module reg8_wr_arbiter
  import reg8_arb_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input logic              clk,
  input logic              reset,
  reg8_wr_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = 4;

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_grant_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_q_valid;

  logic [PTR_W-1:0]  w_sel;
  logic              w_any;
  logic              w_fire;
  logic [NREQ-1:0]   w_ready;
  logic [WIDTH-1:0]  w_data;
  logic [WIDTH-1:0]  w_q;
  logic [PTR_W-1:0]  w_ptr_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
`ifdef REG8_WR_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      w_any = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_any && ((int'(r_ptr) + k) % NREQ) != 0
            && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
          w_any = 1'b1;
          w_sel = PTR_W'((int'(r_ptr) + k) % NREQ);
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && bus.req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_any = 1'b1;
        w_sel = PTR_W'((int'(r_ptr) + k) % NREQ);
      end
    end
`endif
  end

  assign w_fire     = w_any && (r_state == IDLE) && !reset;
  assign w_ready    = w_fire ? (NREQ'(1) << w_sel) : '0;
  assign w_data     = bus.req_data[int'(w_sel)*WIDTH +: WIDTH];
  assign w_ptr_next = (int'(w_sel) == NREQ - 1) ? '0 : w_sel + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_q_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_q_valid  <= 1'b1;
            r_grant_id <= w_sel;
`ifdef REG8_WR_ARB_PRIO0_EN
            // Requester-0 grants bypass the rotation, so they leave it untouched.
            if (w_sel != '0) r_ptr <= w_ptr_next;
`else
            r_ptr <= w_ptr_next;
`endif
            if (HOLD_CYCLES > 0) begin
              r_state <= HOLD;
              r_cnt   <= CNT_W'(HOLD_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  reg8_en #(.WIDTH(WIDTH)) u_q_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_fire),
    .i_d   (w_data),
    .o_q   (w_q)
  );

  assign bus.req_ready = w_ready;
  assign bus.q         = w_q;
  assign bus.q_valid   = r_q_valid;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = (r_state == HOLD);

endmodule

// File: tb/tb_reg8_wr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, per-DUT monitors pop and compare.
// dut_a uses HOLD_CYCLES=2, dut_b uses HOLD_CYCLES=0.
module tb_reg8_wr_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg8_wr_arbiter_if #(.NREQ(4), .WIDTH(8)) ifa ();
  reg8_wr_arbiter_if #(.NREQ(4), .WIDTH(8)) ifb ();

  reg8_wr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  reg8_wr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id; e.data = d;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.id = id; e.data = d;
    qb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for dut_a: grant checked in its cycle, q/grant_id one cycle later.
  initial begin
    exp_t p;
    bit   pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("a_q", ifa.q, p.data);
        check("a_grant_id", ifa.grant_id, p.id);
        check("a_q_valid", ifa.q_valid, 1);
        pend = 1'b0;
      end
      if (ifa.req_ready != '0) begin
        if (qa.size() == 0) begin
          check("a_unexpected_grant", ifa.req_ready, 0);
        end else begin
          p = qa.pop_front();
          check("a_req_ready", ifa.req_ready, 32'(4'b0001 << p.id));
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    exp_t p;
    bit   pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("b_q", ifb.q, p.data);
        check("b_grant_id", ifb.grant_id, p.id);
        check("b_q_valid", ifb.q_valid, 1);
        pend = 1'b0;
      end
      if (ifb.req_ready != '0) begin
        if (qb.size() == 0) begin
          check("b_unexpected_grant", ifb.req_ready, 0);
        end else begin
          p = qb.pop_front();
          check("b_req_ready", ifb.req_ready, 32'(4'b0001 << p.id));
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ifa.req_valid = '0; ifa.req_data = '0;
    ifb.req_valid = '0; ifb.req_data = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_q", ifa.q, 0);
      check("idle_q_valid", ifa.q_valid, 0);
      check("idle_busy", ifa.busy, 0);
      check("idle_ready", ifa.req_ready, 0);
      check("idle_ready_b", ifb.req_ready, 0);
    end

    // Single request from requester 2
    tick();
    push_a(2'd2, 8'hA5);
    ifa.req_data  = 32'h00A5_0000;
    ifa.req_valid = 4'b0100;
    tick();
    ifa.req_valid = '0;
    @(negedge clk); check("single_busy_c1", ifa.busy, 1);
    check("single_ready_in_hold", ifa.req_ready, 0);
    tick();
    @(negedge clk); check("single_busy_c2", ifa.busy, 1);
    tick();
    @(negedge clk); check("single_idle_after_hold", ifa.busy, 0);

    // Reset in the first HOLD cycle; ptr=3 so requester 0 wins by wrap
    tick();
    push_a(2'd0, 8'h5A);
    ifa.req_data  = 32'h0000_005A;
    ifa.req_valid = 4'b0001;
    tick();
    ifa.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midhold_busy", ifa.busy, 0);
    check("midhold_q", ifa.q, 0);
    check("midhold_q_valid", ifa.q_valid, 0);
    check("midhold_grant_id", ifa.grant_id, 0);

    // Round robin with all four valid: 0,1,2,3,0 every third cycle
    tick();
    push_a(2'd0, 8'h10); push_a(2'd1, 8'h11); push_a(2'd2, 8'h12);
    push_a(2'd3, 8'h13); push_a(2'd0, 8'h10);
    ifa.req_data  = 32'h1312_1110;
    ifa.req_valid = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      check("rr_grant_slot", 32'(|ifa.req_ready), 32'((k % 3) == 0));
      tick();
    end
    ifa.req_valid = '0;
    repeat (3) tick();

    // Reset in the same cycle as a would-be grant
    reset = 1'b1;
    ifa.req_data  = 32'h0000_7700;
    ifa.req_valid = 4'b0010;
    @(negedge clk); check("rst_grant_ready", ifa.req_ready, 0);
    tick();
    reset = 1'b0;
    ifa.req_valid = '0;
    @(negedge clk);
    check("rst_grant_q", ifa.q, 0);
    check("rst_grant_q_valid", ifa.q_valid, 0);

    // Requesters 0 and 1 held, then 0 drops
    tick();
`ifdef REG8_WR_ARB_PRIO0_EN
    push_a(2'd0, 8'hB0); push_a(2'd0, 8'hB0); push_a(2'd0, 8'hB0); push_a(2'd1, 8'hB1);
`else
    push_a(2'd0, 8'hB0); push_a(2'd1, 8'hB1); push_a(2'd0, 8'hB0); push_a(2'd1, 8'hB1);
`endif
    ifa.req_data  = 32'h0000_B1B0;
    ifa.req_valid = 4'b0011;
    repeat (7) tick();
    ifa.req_valid = 4'b0010;
    repeat (3) tick();
    ifa.req_valid = '0;
    repeat (3) tick();

    // HOLD_CYCLES=0: requesters 1 and 3 alternate every cycle
    push_b(2'd1, 8'h21); push_b(2'd3, 8'h23); push_b(2'd1, 8'h21); push_b(2'd3, 8'h23);
    ifb.req_data  = 32'h2300_2100;
    ifb.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_busy", ifb.busy, 0);
      check("b2b_grant_present", 32'(|ifb.req_ready), 1);
      tick();
    end
    ifb.req_valid = '0;
    @(negedge clk); check("b2b_busy_end", ifb.busy, 0);

    repeat (5) tick();
    check("queues_drained", 32'(qa.size() + qb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
